tdc_reg_write: RTL and testbench

- Write-side bus master for the TDC chip's 4-bit-address / 28-bit-data parallel register interface. It is the counterpart of TDC_Data_Read, which owns the read strobe.
- Accepts configuration writes from the control logic into a small command FIFO.
- Arbitrates against the reader and generates CSN/WRN strobes with programmable setup, strobe, hold and recovery timing.
- Drives the shared data bus only while it owns it, via a tristate enable.

---
 rtl/tdc_bus_pkg.sv | 26 ++
 rtl/tdc_cmd_fifo.sv | 77 +++++++
 rtl/tdc_reg_write.sv | 161 ++++++++++++++++
 tb/tb_tdc_reg_write.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_bus_pkg.sv
// Shared definitions for the TDC parallel register bus (writer and reader sides).
package tdc_bus_pkg;

    localparam int unsigned TDC_ADDR_W = 4;
    localparam int unsigned TDC_DATA_W = 28;
    localparam int unsigned CYC_W      = 8;

    typedef struct packed {
        logic [TDC_ADDR_W-1:0] addr;
        logic [TDC_DATA_W-1:0] data;
    } tdc_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } tdc_state_e;

    // Counter reload for a phase: a programmed 0 behaves like 1 cycle.
    function automatic logic [CYC_W-1:0] cyc_load(input logic [CYC_W-1:0] cyc);
        return (cyc == '0) ? '0 : cyc - CYC_W'(1);
    endfunction

endpackage

// File: rtl/tdc_cmd_fifo.sv
// Synchronous command FIFO for TDC register writes; flags and overflow are registered.
module tdc_cmd_fifo
    import tdc_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  tdc_cmd_t push_data,
    input  logic     pop,
    output tdc_cmd_t head,
    output logic     full,
    output logic     empty,
    output logic     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    tdc_cmd_t           mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               overflow_q, overflow_d;
    logic               pop_ok_c, push_ok_c, full_now_c;

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    always_comb begin
        full_now_c = (count_q == CNT_W'(DEPTH));
        pop_ok_c   = pop && (count_q != '0);
        push_ok_c  = push && (!full_now_c || pop_ok_c);
        wr_ptr_d   = push_ok_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop_ok_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push_ok_c && !pop_ok_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok_c && pop_ok_c) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d     = full_now_c;
        empty_d    = (count_q == '0);
        overflow_d = overflow_q | (push && full_now_c && !pop_ok_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/tdc_reg_write.sv
// Write-side master for the TDC register bus: queues writes and generates CSN/WRN
// strobes with programmable setup/strobe/hold/recovery timing, arbitrating with the reader.
module tdc_reg_write
    import tdc_bus_pkg::*;
#(
    parameter int unsigned      DEPTH      = 4,
    parameter logic [CYC_W-1:0] SETUP_CYC  = 8'd1,
    parameter logic [CYC_W-1:0] STROBE_CYC = 8'd2,
    parameter logic [CYC_W-1:0] HOLD_CYC   = 8'd1,
    parameter logic [CYC_W-1:0] RECOV_CYC  = 8'd2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [TDC_ADDR_W-1:0] addr_in,
    input  logic [TDC_DATA_W-1:0] data_in,
    input  logic                  rd_busy,
    output logic [TDC_ADDR_W-1:0] addr_out,
    output logic [TDC_DATA_W-1:0] data_out,
    output logic                  data_oe,
    output logic                  CSN,
    output logic                  WRN,
    output logic                  wr_busy,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  done
);

    tdc_state_e            state_q, state_d;
    logic [CYC_W-1:0]      cnt_q, cnt_d;
    logic                  csn_q, csn_d;
    logic                  wrn_q, wrn_d;
    logic                  oe_q, oe_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [TDC_ADDR_W-1:0] addr_q, addr_d;
    logic [TDC_DATA_W-1:0] data_q, data_d;
    logic                  pop_c;
    tdc_cmd_t              head_c;
    tdc_cmd_t              push_cmd_c;

    assign push_cmd_c.addr = addr_in;
    assign push_cmd_c.data = data_in;

    tdc_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (write),
        .push_data (push_cmd_c),
        .pop       (pop_c),
        .head      (head_c),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    // One shared down-counter times every phase; it is reloaded on each state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        csn_d   = csn_q;
        wrn_d   = wrn_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        pop_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && !rd_busy) begin
                    pop_c   = 1'b1;
                    state_d = SETUP;
                    cnt_d   = cyc_load(SETUP_CYC);
                    csn_d   = 1'b0;
                    oe_d    = 1'b1;
                    busy_d  = 1'b1;
                    addr_d  = head_c.addr;
                    data_d  = head_c.data;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = cyc_load(STROBE_CYC);
                    wrn_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CYC_W'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = cyc_load(HOLD_CYC);
                    wrn_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CYC_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    cnt_d   = cyc_load(RECOV_CYC);
                    csn_d   = 1'b1;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CYC_W'(1);
                end
            end
            RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CYC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            csn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csn_q   <= csn_d;
            wrn_q   <= wrn_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign addr_out = addr_q;
    assign data_out = data_q;
    assign data_oe  = oe_q;
    assign CSN      = csn_q;
    assign WRN      = wrn_q;
    assign wr_busy  = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_tdc_reg_write.sv
// Directed bench for tdc_reg_write: default-timing instance plus a slow-timing instance.
module tb_tdc_reg_write;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset   = 1'b1;
    logic        write   = 1'b0;
    logic [3:0]  addr_in = '0;
    logic [27:0] data_in = '0;
    logic        rd_busy = 1'b0;
    logic [3:0]  addr_out;
    logic [27:0] data_out;
    logic        data_oe, CSN, WRN, wr_busy, full, empty, overflow, done;

    logic        write2   = 1'b0;
    logic [3:0]  addr_in2 = '0;
    logic [27:0] data_in2 = '0;
    logic        rd_busy2 = 1'b0;
    logic [3:0]  addr_out2;
    logic [27:0] data_out2;
    logic        data_oe2, CSN2, WRN2, wr_busy2, full2, empty2, overflow2, done2;

    tdc_reg_write #(
        .DEPTH(4), .SETUP_CYC(8'd1), .STROBE_CYC(8'd2), .HOLD_CYC(8'd1), .RECOV_CYC(8'd2)
    ) dut (
        .clk(clk), .reset(reset), .write(write), .addr_in(addr_in), .data_in(data_in),
        .rd_busy(rd_busy), .addr_out(addr_out), .data_out(data_out), .data_oe(data_oe),
        .CSN(CSN), .WRN(WRN), .wr_busy(wr_busy), .full(full), .empty(empty),
        .overflow(overflow), .done(done)
    );

    tdc_reg_write #(
        .DEPTH(4), .SETUP_CYC(8'd0), .STROBE_CYC(8'd5), .HOLD_CYC(8'd3), .RECOV_CYC(8'd1)
    ) dut2 (
        .clk(clk), .reset(reset), .write(write2), .addr_in(addr_in2), .data_in(data_in2),
        .rd_busy(rd_busy2), .addr_out(addr_out2), .data_out(data_out2), .data_oe(data_oe2),
        .CSN(CSN2), .WRN(WRN2), .wr_busy(wr_busy2), .full(full2), .empty(empty2),
        .overflow(overflow2), .done(done2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edge monitor: cyc equals the number of rising edges seen so far.
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic        csn_p = 1'b1, csn2_p = 1'b1, wrn2_p = 1'b1;
    int          fall_cyc[$];
    logic [3:0]  fall_addr[$];
    logic [27:0] fall_data[$];
    int          n_done = 0;
    int          c2_fall[$], c2_rise[$], w2_fall[$], w2_rise[$];

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (csn_p && !CSN) begin
                fall_cyc.push_back(cyc);
                fall_addr.push_back(addr_out);
                fall_data.push_back(data_out);
            end
            if (done) n_done++;
            if (csn2_p && !CSN2) c2_fall.push_back(cyc);
            if (!csn2_p && CSN2) c2_rise.push_back(cyc);
            if (wrn2_p && !WRN2) w2_fall.push_back(cyc);
            if (!wrn2_p && WRN2) w2_rise.push_back(cyc);
        end
        csn_p  = CSN;
        csn2_p = CSN2;
        wrn2_p = WRN2;
    end

    typedef struct packed {
        logic        wr;
        logic [3:0]  a;
        logic [27:0] d;
        logic        csn, wrn, oe, dn, busy, emp;
        logic [3:0]  ao;
        logic [27:0] dout;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic csn, input logic wrn, input logic oe,
                                input logic dn, input logic busy, input logic emp,
                                input logic [3:0] ao, input logic [27:0] dout);
        vec_t v;
        v.wr = wr; v.a = 4'h3; v.d = 28'h00A5F21;
        v.csn = csn; v.wrn = wrn; v.oe = oe; v.dn = dn; v.busy = busy; v.emp = emp;
        v.ao = ao; v.dout = dout;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        int   base, nd, b, waited;
        logic [27:0] dat;

        // Single write with default timing; row i is the state after edge k+i.
        tbl[0] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 28'h0);
        tbl[1] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 28'h0);
        tbl[2] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 28'h00A5F21);
        tbl[3] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 28'h00A5F21);
        tbl[4] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 28'h00A5F21);
        tbl[5] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 28'h00A5F21);
        tbl[6] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 28'h00A5F21);
        tbl[7] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 28'h00A5F21);
        tbl[8] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 28'h00A5F21);
        tbl[9] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 28'h00A5F21);

        step();
        step();
        chk("rst_csn", 32'(CSN), 1);
        chk("rst_wrn", 32'(WRN), 1);
        chk("rst_oe", 32'(data_oe), 0);
        chk("rst_addr", 32'(addr_out), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_busy", 32'(wr_busy), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_done", 32'(done), 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            write   = tbl[i].wr;
            addr_in = tbl[i].a;
            data_in = tbl[i].d;
            step();
            chk($sformatf("single[%0d].csn", i), 32'(CSN), 32'(tbl[i].csn));
            chk($sformatf("single[%0d].wrn", i), 32'(WRN), 32'(tbl[i].wrn));
            chk($sformatf("single[%0d].oe", i), 32'(data_oe), 32'(tbl[i].oe));
            chk($sformatf("single[%0d].done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("single[%0d].busy", i), 32'(wr_busy), 32'(tbl[i].busy));
            chk($sformatf("single[%0d].empty", i), 32'(empty), 32'(tbl[i].emp));
            chk($sformatf("single[%0d].addr", i), 32'(addr_out), 32'(tbl[i].ao));
            chk($sformatf("single[%0d].data", i), 32'(data_out), 32'(tbl[i].dout));
        end

        // Back-to-back: three writes on consecutive cycles.
        base = fall_cyc.size();
        nd   = n_done;
        for (int i = 0; i < 3; i++) begin
            write   = 1'b1;
            addr_in = 4'(i + 1);
            data_in = 28'h0ABC000 + 28'(i);
            step();
        end
        write = 1'b0;
        repeat (25) step();
        chk("b2b_accesses", 32'(fall_cyc.size() - base), 3);
        chk("b2b_dones", 32'(n_done - nd), 3);
        for (int i = 0; i < 3; i++) begin
            if (fall_cyc.size() > base + i) begin
                chk($sformatf("b2b_addr[%0d]", i), 32'(fall_addr[base + i]), 32'(i + 1));
                chk($sformatf("b2b_data[%0d]", i), 32'(fall_data[base + i]), 32'h0ABC000 + 32'(i));
                if (i > 0) begin
                    chk($sformatf("b2b_spacing[%0d]", i),
                        32'(fall_cyc[base + i] - fall_cyc[base + i - 1]), 7);
                end
            end
        end
        chk("b2b_empty", 32'(empty), 1);
        chk("b2b_ovf", 32'(overflow), 0);

        // Overflow: six writes while the reader holds the bus.
        reset = 1'b1;
        step();
        reset   = 1'b0;
        rd_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            write   = 1'b1;
            addr_in = 4'h8 + 4'(i);
            data_in = 28'h1230000 + 28'(i);
            step();
            if (i == 3) chk("ovf_not_yet", 32'(overflow), 0);
            if (i == 4) begin
                chk("ovf_full", 32'(full), 1);
                chk("ovf_set", 32'(overflow), 1);
            end
        end
        write = 1'b0;
        base  = fall_cyc.size();
        repeat (3) step();
        chk("arb_csn_held", 32'(CSN), 1);
        chk("arb_wr_busy_low", 32'(wr_busy), 0);
        chk("arb_no_access", 32'(fall_cyc.size() - base), 0);
        rd_busy = 1'b0;
        repeat (35) step();
        chk("ovf_accesses", 32'(fall_cyc.size() - base), 4);
        for (int i = 0; i < 4; i++) begin
            if (fall_cyc.size() > base + i) begin
                chk($sformatf("ovf_addr[%0d]", i), 32'(fall_addr[base + i]), 32'h8 + 32'(i));
                chk($sformatf("ovf_data[%0d]", i), 32'(fall_data[base + i]), 32'h1230000 + 32'(i));
            end
        end
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ovf_empty", 32'(empty), 1);
        chk("ovf_full_clear", 32'(full), 0);

        // Arbitration: release rd_busy, then raise it during STROBE.
        reset = 1'b1;
        step();
        reset   = 1'b0;
        rd_busy = 1'b1;
        write   = 1'b1;
        addr_in = 4'h5;
        data_in = 28'h5555555;
        step();
        write = 1'b0;
        repeat (5) step();
        chk("arb_hold_csn", 32'(CSN), 1);
        chk("arb_hold_busy", 32'(wr_busy), 0);
        chk("arb_hold_empty", 32'(empty), 0);
        rd_busy = 1'b0;
        step();
        chk("arb_csn_fall", 32'(CSN), 0);
        chk("arb_busy_high", 32'(wr_busy), 1);
        chk("arb_addr", 32'(addr_out), 5);
        step();
        chk("arb_wrn_low", 32'(WRN), 0);
        rd_busy = 1'b1;
        step();
        chk("arb_strobe_wrn", 32'(WRN), 0);
        chk("arb_strobe_csn", 32'(CSN), 0);
        step();
        chk("arb_done", 32'(done), 1);
        chk("arb_wrn_high", 32'(WRN), 1);
        step();
        chk("arb_csn_rise", 32'(CSN), 1);
        chk("arb_oe_low", 32'(data_oe), 0);
        chk("arb_data_kept", 32'(data_out), 32'h5555555);
        rd_busy = 1'b0;
        repeat (4) step();

        // Reset in the middle of a strobe with a second entry still queued.
        for (int i = 0; i < 2; i++) begin
            write   = 1'b1;
            addr_in = 4'hA + 4'(i);
            data_in = 28'h0F0F0F0;
            step();
        end
        write  = 1'b0;
        waited = 0;
        while (WRN !== 1'b0 && waited < 10) begin
            step();
            waited++;
        end
        chk("rst_mid_reach_strobe", 32'(WRN), 0);
        nd     = n_done;
        reset  = 1'b1;
        step();
        chk("rst_mid_wrn", 32'(WRN), 1);
        chk("rst_mid_csn", 32'(CSN), 1);
        chk("rst_mid_oe", 32'(data_oe), 0);
        chk("rst_mid_empty", 32'(empty), 1);
        chk("rst_mid_done", 32'(done), 0);
        reset = 1'b0;
        base  = fall_cyc.size();
        repeat (20) step();
        chk("rst_mid_no_access", 32'(fall_cyc.size() - base), 0);
        chk("rst_mid_no_done", 32'(n_done - nd), 0);

        // Slow-timing instance: two back-to-back writes.
        b = c2_fall.size();
        for (int i = 0; i < 2; i++) begin
            write2   = 1'b1;
            addr_in2 = 4'h1 + 4'(i);
            dat      = 28'h7000000 + 28'(i);
            data_in2 = dat;
            step();
        end
        write2 = 1'b0;
        repeat (30) step();
        chk("t2_accesses", 32'(c2_fall.size() - b), 2);
        if (c2_fall.size() >= b + 2 && w2_fall.size() > b && w2_rise.size() > b && c2_rise.size() > b) begin
            chk("t2_setup", 32'(w2_fall[b] - c2_fall[b]), 1);
            chk("t2_strobe", 32'(w2_rise[b] - w2_fall[b]), 5);
            chk("t2_csn_low", 32'(c2_rise[b] - c2_fall[b]), 9);
            chk("t2_period", 32'(c2_fall[b + 1] - c2_fall[b]), 11);
        end
        chk("t2_addr_last", 32'(addr_out2), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
